tx_arbiter: RTL and testbench

//  Packet-atomic arbiter sharing the single network_tx AXI-Stream egress among three sources:
//  app2net handshakes, net2app handshakes and app2net bulk data.

---
 rtl/tx_arb_pkg.sv | 35 +++
 rtl/tx_arbiter_if.sv | 24 ++
 rtl/tx_out_reg.sv | 36 +++
 rtl/tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_tx_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_arb_pkg.sv
// Shared types and defaults for the network TX egress arbiter.
//   arb_state_e : arbiter FSM states
//   src_id_t    : source identifiers used by the grant demux/mux
package tx_arb_pkg;

  localparam int unsigned TX_DATA_W       = 512;
  localparam int unsigned TX_DEST_W       = 16;
  localparam int unsigned TX_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_N = 2'd2,
    GNT_D = 2'd3
  } arb_state_e;

  localparam int unsigned SRC_W = 2;
  typedef logic [SRC_W-1:0] src_id_t;

  localparam src_id_t SRC_A    = 2'd0;
  localparam src_id_t SRC_N    = 2'd1;
  localparam src_id_t SRC_D    = 2'd2;
  localparam src_id_t SRC_NONE = 2'd3;

  // Source currently owning the egress, SRC_NONE while idle.
  function automatic src_id_t granted_src(input arb_state_e s);
    case (s)
      GNT_A:   return SRC_A;
      GNT_N:   return SRC_N;
      GNT_D:   return SRC_D;
      default: return SRC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tx_arbiter_if.sv
// AXI-Stream link used for the three arbiter sources and the egress.
//   master : drives tdata/tkeep/tstrb/tlast/tdest/tvalid, samples tready
//   slave  : samples payload and tvalid, drives tready
interface tx_axis_if
  import tx_arb_pkg::*;
#(
  parameter int unsigned DATA_W = TX_DATA_W,
  parameter int unsigned DEST_W = TX_DEST_W
) ();

  localparam int unsigned KEEP_W = DATA_W / 8;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [KEEP_W-1:0] tstrb;
  logic              tlast;
  logic [DEST_W-1:0] tdest;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tkeep, tstrb, tlast, tdest, tvalid, input tready);
  modport slave  (input tdata, tkeep, tstrb, tlast, tdest, tvalid, output tready);

endinterface

// File: rtl/tx_out_reg.sv
// One-entry AXI-Stream output register.
//   ap_clk/ap_rst : clock, synchronous active-high reset
//   load          : beat accepted from the granted source this cycle
//   din/dout      : packed beat in / registered beat out
//   egress_ready  : downstream tready
//   full          : register holds a beat (drives egress tvalid)
//   full_nxt_c    : combinational next value of full
module tx_out_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             egress_ready,
  output logic             full,
  output logic             full_nxt_c,
  output logic [WIDTH-1:0] dout
);

  // A simultaneous load and drain keeps the register full with the new beat.
  always_comb begin
    full_nxt_c = load | (full & ~egress_ready);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      full <= 1'b0;
      dout <= '0;
    end else begin
      full <= full_nxt_c;
      if (load) dout <= din;
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Packet-atomic arbiter sharing the network TX egress among three sources.
// Fixed priority app2net_hs > net2app_hs > app2net_data, with a starvation
// override for data; stall only holds off new packets.
//   ap_clk/ap_rst     : clock, synchronous active-high reset
//   stall             : hold off new grants (sampled in IDLE only)
//   app2net_hs_tx     : source A (slave)
//   net2app_hs_tx     : source N (slave)
//   app2net_data_tx   : source D (slave)
//   network_tx        : egress stream (master), fed from a one-entry register
//   busy              : grant held or output register full
//   pkt_sent          : egress beats with tlast accepted, wrapping
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int unsigned DATA_W       = TX_DATA_W,
  parameter int unsigned DEST_W       = TX_DEST_W,
  parameter int unsigned STARVE_LIMIT = TX_STARVE_LIMIT
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        stall,
  tx_axis_if.slave    app2net_hs_tx,
  tx_axis_if.slave    net2app_hs_tx,
  tx_axis_if.slave    app2net_data_tx,
  tx_axis_if.master   network_tx,
  output logic        busy,
  output logic [31:0] pkt_sent
);

  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [KEEP_W-1:0] tstrb;
    logic              tlast;
    logic [DEST_W-1:0] tdest;
  } beat_t;

  localparam int unsigned BEAT_W = $bits(beat_t);

  arb_state_e       state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_nxt, starve_inc;
  logic             starve_hit;
  src_id_t          src_sel;
  logic             slot_ready, in_valid, accept, out_full, full_nxt;
  beat_t            in_beat, out_beat;

  assign src_sel = granted_src(state);

  // Room for a beat when empty, or when the held beat leaves this cycle.
  assign slot_ready = ~out_full | network_tx.tready;

  assign app2net_hs_tx.tready   = (src_sel == SRC_A) & slot_ready;
  assign net2app_hs_tx.tready   = (src_sel == SRC_N) & slot_ready;
  assign app2net_data_tx.tready = (src_sel == SRC_D) & slot_ready;

  // Payload mux from the granted source.
  always_comb begin
    in_valid = 1'b0;
    in_beat  = '0;
    case (src_sel)
      SRC_A: begin
        in_valid = app2net_hs_tx.tvalid;
        in_beat  = {app2net_hs_tx.tdata, app2net_hs_tx.tkeep, app2net_hs_tx.tstrb,
                    app2net_hs_tx.tlast, app2net_hs_tx.tdest};
      end
      SRC_N: begin
        in_valid = net2app_hs_tx.tvalid;
        in_beat  = {net2app_hs_tx.tdata, net2app_hs_tx.tkeep, net2app_hs_tx.tstrb,
                    net2app_hs_tx.tlast, net2app_hs_tx.tdest};
      end
      SRC_D: begin
        in_valid = app2net_data_tx.tvalid;
        in_beat  = {app2net_data_tx.tdata, app2net_data_tx.tkeep, app2net_data_tx.tstrb,
                    app2net_data_tx.tlast, app2net_data_tx.tdest};
      end
      default: ;
    endcase
  end

  assign accept     = in_valid & slot_ready;
  assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign starve_inc = starve_hit ? starve_cnt : starve_cnt + CNT_W'(1);

  // Grant selection in IDLE; a granted source keeps the egress until its tlast beat.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    case (state)
      IDLE: begin
        if (!stall) begin
          if (starve_hit && app2net_data_tx.tvalid) begin
            state_nxt  = GNT_D;
            starve_nxt = '0;
          end else if (app2net_hs_tx.tvalid) begin
            state_nxt  = GNT_A;
            starve_nxt = app2net_data_tx.tvalid ? starve_inc : '0;
          end else if (net2app_hs_tx.tvalid) begin
            state_nxt  = GNT_N;
            starve_nxt = app2net_data_tx.tvalid ? starve_inc : '0;
          end else if (app2net_data_tx.tvalid) begin
            state_nxt  = GNT_D;
            starve_nxt = '0;
          end
        end
      end
      default: begin
        if (accept && in_beat.tlast) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      busy       <= 1'b0;
      pkt_sent   <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      busy       <= (state_nxt != IDLE) | full_nxt;
      if (out_full && network_tx.tready && out_beat.tlast) pkt_sent <= pkt_sent + 32'd1;
    end
  end

  tx_out_reg #(
    .WIDTH (BEAT_W)
  ) u_out_reg (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .load         (accept),
    .din          (in_beat),
    .egress_ready (network_tx.tready),
    .full         (out_full),
    .full_nxt_c   (full_nxt),
    .dout         (out_beat)
  );

  assign network_tx.tvalid = out_full;
  assign network_tx.tdata  = out_beat.tdata;
  assign network_tx.tkeep  = out_beat.tkeep;
  assign network_tx.tstrb  = out_beat.tstrb;
  assign network_tx.tlast  = out_beat.tlast;
  assign network_tx.tdest  = out_beat.tdest;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: queued source drivers, egress and grant monitors,
// hand-ordered expected beat sequences and cycle offsets.
module tb_tx_arbiter;
  import tx_arb_pkg::*;

  localparam int unsigned DW = 512;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned SW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [KW-1:0] strb;
    logic          last;
    logic [SW-1:0] dest;
  } beat_t;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        stall;
  logic        busy;
  logic [31:0] pkt_sent;

  tx_axis_if #(.DATA_W(DW), .DEST_W(SW)) a_if ();
  tx_axis_if #(.DATA_W(DW), .DEST_W(SW)) n_if ();
  tx_axis_if #(.DATA_W(DW), .DEST_W(SW)) d_if ();
  tx_axis_if #(.DATA_W(DW), .DEST_W(SW)) nt_if ();

  tx_arbiter dut (
    .ap_clk          (ap_clk),
    .ap_rst          (ap_rst),
    .stall           (stall),
    .app2net_hs_tx   (a_if),
    .net2app_hs_tx   (n_if),
    .app2net_data_tx (d_if),
    .network_tx      (nt_if),
    .busy            (busy),
    .pkt_sent        (pkt_sent)
  );

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  beat_t q_a[$], q_n[$], q_d[$], eg_q[$];
  int    eg_t[$], gnt_q[$], gnt_starve[$], gnt_t[$];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input logic [7:0] tg, input int idx, input bit last);
    beat_t b;
    b.data             = '0;
    b.data[31:0]       = {tg, 8'(idx), 16'hC0DE};
    b.data[DW-1 -: 32] = {16'hBEEF, tg, 8'(idx)};
    b.keep             = {KW{1'b1}} >> idx;
    b.strb             = ~(64'(1) << idx);
    b.last             = last;
    b.dest             = {tg, 8'(idx)};
    return b;
  endfunction

  function automatic int stamp(input int i);
    return (i < eg_t.size()) ? eg_t[i] : -1000;
  endfunction

  function automatic int gnt_at(input int i);
    return (i < gnt_q.size()) ? gnt_q[i] : -1;
  endfunction

  function automatic int starve_at(input int i);
    return (i < gnt_starve.size()) ? gnt_starve[i] : -1;
  endfunction

  function automatic int gnt_time(input int i);
    return (i < gnt_t.size()) ? gnt_t[i] : -1000;
  endfunction

  task automatic check_beat(input string tag, input int i, input beat_t exp);
    beat_t got;
    got = (i < eg_q.size()) ? eg_q[i] : '0;
    check({tag, "_data"}, got.data, exp.data);
    check({tag, "_side"}, 512'({got.keep, got.strb, got.last, got.dest}),
                          512'({exp.keep, exp.strb, exp.last, exp.dest}));
  endtask

  task automatic push_pkt(input int src, input logic [7:0] tg, input int n);
    for (int i = 0; i < n; i++) begin
      case (src)
        0:       q_a.push_back(mk(tg, i, i == n - 1));
        1:       q_n.push_back(mk(tg, i, i == n - 1));
        default: q_d.push_back(mk(tg, i, i == n - 1));
      endcase
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  task automatic wait_egress(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (eg_q.size() < n && k < budget) begin
      @(posedge ap_clk);
      k++;
    end
    #1;
    check(tag, 512'(eg_q.size()), 512'(n));
  endtask

  task automatic do_reset();
    @(posedge ap_clk);
    #1;
    ap_rst        = 1'b1;
    stall         = 1'b0;
    nt_if.tready  = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    eg_q.delete(); eg_t.delete();
    gnt_q.delete(); gnt_starve.delete(); gnt_t.delete();
    tick(1);
  endtask

  // Source drivers: present queue heads, pop after a handshake, flush on reset.
  initial begin
    bit hs_a, hs_n, hs_d, rst_seen;
    forever begin
      @(negedge ap_clk);
      hs_a     = (a_if.tvalid === 1'b1) && (a_if.tready === 1'b1);
      hs_n     = (n_if.tvalid === 1'b1) && (n_if.tready === 1'b1);
      hs_d     = (d_if.tvalid === 1'b1) && (d_if.tready === 1'b1);
      rst_seen = ap_rst;
      @(posedge ap_clk);
      #2;
      if (rst_seen) begin
        q_a.delete(); q_n.delete(); q_d.delete();
      end else begin
        if (hs_a && q_a.size() != 0) void'(q_a.pop_front());
        if (hs_n && q_n.size() != 0) void'(q_n.pop_front());
        if (hs_d && q_d.size() != 0) void'(q_d.pop_front());
      end
      if (q_a.size() != 0) begin
        {a_if.tdata, a_if.tkeep, a_if.tstrb, a_if.tlast, a_if.tdest} = q_a[0];
        a_if.tvalid = 1'b1;
      end else begin
        {a_if.tdata, a_if.tkeep, a_if.tstrb, a_if.tlast, a_if.tdest} = '0;
        a_if.tvalid = 1'b0;
      end
      if (q_n.size() != 0) begin
        {n_if.tdata, n_if.tkeep, n_if.tstrb, n_if.tlast, n_if.tdest} = q_n[0];
        n_if.tvalid = 1'b1;
      end else begin
        {n_if.tdata, n_if.tkeep, n_if.tstrb, n_if.tlast, n_if.tdest} = '0;
        n_if.tvalid = 1'b0;
      end
      if (q_d.size() != 0) begin
        {d_if.tdata, d_if.tkeep, d_if.tstrb, d_if.tlast, d_if.tdest} = q_d[0];
        d_if.tvalid = 1'b1;
      end else begin
        {d_if.tdata, d_if.tkeep, d_if.tstrb, d_if.tlast, d_if.tdest} = '0;
        d_if.tvalid = 1'b0;
      end
    end
  end

  // Egress monitor: record each beat that will hand off at the next edge.
  initial begin
    forever begin
      @(negedge ap_clk);
      if (ap_rst === 1'b0 && nt_if.tvalid === 1'b1 && nt_if.tready === 1'b1) begin
        eg_q.push_back({nt_if.tdata, nt_if.tkeep, nt_if.tstrb, nt_if.tlast, nt_if.tdest});
        eg_t.push_back(cyc + 1);
      end
    end
  end

  // Grant monitor: record IDLE -> GNT_x transitions and starve_cnt after the decision.
  initial begin
    int prev, cur;
    prev = 0;
    forever begin
      @(negedge ap_clk);
      cur = int'(dut.state);
      if (ap_rst === 1'b0 && cur != 0 && prev == 0) begin
        gnt_q.push_back(cur);
        gnt_starve.push_back(int'(dut.starve_cnt));
        gnt_t.push_back(cyc);
      end
      prev = cur;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t exp_q[$];
    beat_t b;
    int    t0, s;
    int    exp_g[5];
    int    exp_s[5];

    ap_rst       = 1'b1;
    stall        = 1'b0;
    nt_if.tready = 1'b1;
    {a_if.tdata, a_if.tkeep, a_if.tstrb, a_if.tlast, a_if.tdest, a_if.tvalid} = '0;
    {n_if.tdata, n_if.tkeep, n_if.tstrb, n_if.tlast, n_if.tdest, n_if.tvalid} = '0;
    {d_if.tdata, d_if.tkeep, d_if.tstrb, d_if.tlast, d_if.tdest, d_if.tvalid} = '0;

    // Reset state
    do_reset();
    @(negedge ap_clk);
    check("rst_state",  512'(int'(dut.state)), 512'(0));
    check("rst_starve", 512'(int'(dut.starve_cnt)), 512'(0));
    check("rst_tvalid", 512'(nt_if.tvalid), 512'(0));
    check("rst_rdy_a",  512'(a_if.tready), 512'(0));
    check("rst_rdy_n",  512'(n_if.tready), 512'(0));
    check("rst_rdy_d",  512'(d_if.tready), 512'(0));
    check("rst_busy",   512'(busy), 512'(0));
    check("rst_pkts",   512'(pkt_sent), 512'(0));
    check("rst_tdata",  nt_if.tdata, 512'(0));

    // 1: A and D together -> A packet, one bubble, D packet
    @(posedge ap_clk);
    #1;
    t0 = cyc;
    push_pkt(0, 8'hA1, 2);
    push_pkt(2, 8'hD1, 3);
    wait_egress(5, 40, "t1_count");
    check_beat("t1_b0", 0, mk(8'hA1, 0, 0));
    check_beat("t1_b1", 1, mk(8'hA1, 1, 1));
    check_beat("t1_b2", 2, mk(8'hD1, 0, 0));
    check_beat("t1_b3", 3, mk(8'hD1, 1, 0));
    check_beat("t1_b4", 4, mk(8'hD1, 2, 1));
    check("t1_latency", 512'(stamp(0) - t0), 512'(3));
    check("t1_a_run",   512'(stamp(1) - stamp(0)), 512'(1));
    check("t1_bubble",  512'(stamp(2) - stamp(1)), 512'(2));
    check("t1_d_run",   512'(stamp(4) - stamp(2)), 512'(2));
    tick(3);
    check("t1_pkts", 512'(pkt_sent), 512'(2));
    check("t1_busy", 512'(busy), 512'(0));

    // 2: starvation override after four handshake grants
    do_reset();
    for (int p = 0; p < 5; p++) begin
      q_a.push_back(mk(8'hA2, p, 1'b1));
      q_n.push_back(mk(8'h2B, p, 1'b1));
    end
    q_d.push_back(mk(8'hD2, 0, 1'b1));
    wait_egress(11, 150, "t2_count");
    exp_g = '{1, 1, 1, 1, 3};
    exp_s = '{1, 2, 3, 4, 0};
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_gnt%0d", i),    512'(gnt_at(i)), 512'(exp_g[i]));
      check($sformatf("t2_starve%0d", i), 512'(starve_at(i)), 512'(exp_s[i]));
    end
    exp_q.delete();
    for (int p = 0; p < 4; p++) exp_q.push_back(mk(8'hA2, p, 1'b1));
    exp_q.push_back(mk(8'hD2, 0, 1'b1));
    exp_q.push_back(mk(8'hA2, 4, 1'b1));
    for (int p = 0; p < 5; p++) exp_q.push_back(mk(8'h2B, p, 1'b1));
    for (int i = 0; i < 11; i++) check_beat($sformatf("t2_b%0d", i), i, exp_q[i]);

    // 3: stall during a D packet; A waits until stall drops
    do_reset();
    push_pkt(2, 8'hD3, 4);
    tick(3);
    stall = 1'b1;
    push_pkt(0, 8'hA3, 1);
    tick(5);
    check("t3_no_gnt_in_stall", 512'(gnt_q.size()), 512'(1));
    stall = 1'b0;
    s     = cyc;
    wait_egress(5, 40, "t3_count");
    for (int i = 0; i < 4; i++) check_beat($sformatf("t3_d%0d", i), i, mk(8'hD3, i, i == 3));
    check_beat("t3_a0", 4, mk(8'hA3, 0, 1'b1));
    check("t3_gnt_dly",   512'(gnt_time(1) - s), 512'(1));
    check("t3_gnt_src",   512'(gnt_at(1)), 512'(1));
    check("t3_a_egress",  512'(stamp(4) - s), 512'(3));

    // 4: egress backpressure while N beat 1 sits in the register
    do_reset();
    push_pkt(1, 8'h4E, 3);
    tick(3);
    nt_if.tready = 1'b0;
    b = mk(8'h4E, 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      check($sformatf("t4_hold_valid%0d", i), 512'(nt_if.tvalid), 512'(1));
      check($sformatf("t4_hold_data%0d", i),  nt_if.tdata, b.data);
      check($sformatf("t4_hold_dest%0d", i),  512'(nt_if.tdest), 512'(b.dest));
      check($sformatf("t4_n_ready%0d", i),    512'(n_if.tready), 512'(0));
      @(posedge ap_clk);
      #1;
    end
    nt_if.tready = 1'b1;
    wait_egress(3, 30, "t4_count");
    tick(4);
    check("t4_count_final", 512'(eg_q.size()), 512'(3));
    for (int i = 0; i < 3; i++) check_beat($sformatf("t4_b%0d", i), i, mk(8'h4E, i, i == 2));
    check("t4_pkts", 512'(pkt_sent), 512'(1));

    // 5: reset mid D packet discards it; a fresh A packet follows
    do_reset();
    push_pkt(2, 8'hD5, 4);
    tick(3);
    ap_rst = 1'b1;
    tick(1);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("t5_tvalid", 512'(nt_if.tvalid), 512'(0));
    check("t5_rdy_a",  512'(a_if.tready), 512'(0));
    check("t5_rdy_n",  512'(n_if.tready), 512'(0));
    check("t5_rdy_d",  512'(d_if.tready), 512'(0));
    check("t5_state",  512'(int'(dut.state)), 512'(0));
    check("t5_pkts",   512'(pkt_sent), 512'(0));
    check("t5_busy",   512'(busy), 512'(0));
    push_pkt(0, 8'hA5, 2);
    wait_egress(3, 30, "t5_count");
    check_beat("t5_b0", 0, mk(8'hD5, 0, 1'b0));
    check_beat("t5_b1", 1, mk(8'hA5, 0, 1'b0));
    check_beat("t5_b2", 2, mk(8'hA5, 1, 1'b1));
    tick(3);
    check("t5_pkts_after", 512'(pkt_sent), 512'(1));
    check("t5_count_final", 512'(eg_q.size()), 512'(3));

    // 6: full-throughput 8-beat D packet
    do_reset();
    push_pkt(2, 8'hD6, 8);
    wait_egress(8, 40, "t6_count");
    for (int i = 0; i < 8; i++) check_beat($sformatf("t6_b%0d", i), i, mk(8'hD6, i, i == 7));
    check("t6_burst", 512'(stamp(7) - stamp(0)), 512'(7));
    tick(3);
    check("t6_pkts", 512'(pkt_sent), 512'(1));
    check("t6_busy", 512'(busy), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
